// File: rtl/pixel_fb_writer.sv
// Pixel FIFO plus framebuffer write generator with raster addressing and valid/ready handshake.
// Optional build macro FB_VFLIP_EN: rows are written bottom-up (BMP order) instead of top-down.
module pixel_fb_writer #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [15:0]       pixel_data,
    input  logic              pixel_valid,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_wdata,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned X_W   = $clog2(H_RES + 1);
    localparam int unsigned Y_W   = $clog2(V_RES + 1);

    localparam logic [X_W-1:0]    X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(V_RES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
`ifdef FB_VFLIP_EN
    localparam logic [ADDR_W-1:0] FIRST_BASE = ADDR_W'((V_RES - 1) * H_RES);
    localparam logic [ADDR_W-1:0] H_STEP     = ADDR_W'(H_RES);
`else
    localparam logic [ADDR_W-1:0] FIRST_BASE = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_after_pop;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
`ifdef FB_VFLIP_EN
    logic [ADDR_W-1:0] row_base_q, row_base_d;
`endif
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]       fb_wdata_q, fb_wdata_d;
    logic              fb_we_q, fb_we_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic pop, push, full, last_pix;

    assign pop      = fb_we_q & fb_ready;
    assign full     = (count_q == CNT_MAX);
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
    assign push     = (state_q == WRITE) && pixel_valid && !frame_start && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = WRITE;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                WRITE:   if (pop && last_pix) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        x_d        = x_q;
        y_d        = y_q;
`ifdef FB_VFLIP_EN
        row_base_d = row_base_q;
`endif
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        overflow_d = overflow_q;
        count_after_pop = count_q - (pop ? CNT_ONE : '0);

        if (frame_start) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            x_d        = '0;
            y_d        = '0;
`ifdef FB_VFLIP_EN
            row_base_d = FIRST_BASE;
`endif
            fb_addr_d  = FIRST_BASE;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                // Address holds on the final pixel so it never wraps past the frame.
                if (!last_pix) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
`ifdef FB_VFLIP_EN
                        row_base_d = row_base_q - H_STEP;
                        fb_addr_d  = row_base_q - H_STEP;
`else
                        fb_addr_d  = fb_addr_q + ADDR_ONE;
`endif
                    end else begin
                        x_d       = x_q + X_W'(1);
                        fb_addr_d = fb_addr_q + ADDR_ONE;
                    end
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            count_d = count_after_pop + (push ? CNT_ONE : '0);
            if ((state_q == WRITE) && pixel_valid && !push) begin
                overflow_d = 1'b1;
            end
        end

        // Stage next head: bypass the incoming pixel when the FIFO drains empty this cycle.
        if (count_d != '0) begin
            if (count_after_pop == '0) begin
                fb_wdata_d = pixel_data;
            end else begin
                fb_wdata_d = mem_q[rd_ptr_d];
            end
        end

        fb_we_d      = (state_d == WRITE) && (count_d != '0);
        busy_d       = (state_d == WRITE);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pixel_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
`ifdef FB_VFLIP_EN
            row_base_q   <= '0;
`endif
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            fb_we_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
`ifdef FB_VFLIP_EN
            row_base_q   <= row_base_d;
`endif
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            fb_we_q      <= fb_we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign fb_we      = fb_we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Randomized and directed bench for pixel_fb_writer (H_RES=4, V_RES=3, FIFO_DEPTH=8)
// against a queue-based frame model.
module tb_pixel_fb_writer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic [16:0] fb_addr;
    logic [15:0] fb_wdata;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    pixel_fb_writer #(
        .H_RES(4),
        .V_RES(3),
        .ADDR_W(17),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .fb_addr(fb_addr),
        .fb_wdata(fb_wdata),
        .fb_we(fb_we),
        .fb_ready(fb_ready),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int done_cnt = 0;
    int exp1 [N];

    bit          m_wr = 1'b0;
    logic [15:0] m_q [$];
    int          m_k = 0;
    bit          m_ovf = 1'b0;
    bit          m_done = 1'b0;
    int          log_addr [$];
    int          log_data [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_addr(input int k);
`ifdef FB_VFLIP_EN
        return (V - 1 - k / H) * H + k % H;
`else
        return k;
`endif
    endfunction

    function automatic bit exp_we();
        return m_wr && (m_q.size() > 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_wr = 1'b0; m_q.delete(); m_k = 0; m_ovf = 1'b0; m_done = 1'b0;
            end else begin
                bit acc;
                acc = exp_we() && fb_ready;
                if (fb_we && fb_ready) begin
                    log_addr.push_back(int'(fb_addr));
                    log_data.push_back(int'(fb_wdata));
                end
                m_done = 1'b0;
                if (frame_start) begin
                    m_q.delete(); m_k = 0; m_ovf = 1'b0; m_wr = 1'b1;
                end else if (m_wr) begin
                    if (acc) begin
                        void'(m_q.pop_front());
                        m_k++;
                        if (m_k == N) begin
                            m_wr = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                    if (pixel_valid) begin
                        if (m_q.size() < D) m_q.push_back(pixel_data);
                        else m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", int'(busy), int'(m_wr));
            chk("fb_we", int'(fb_we), int'(exp_we()));
            chk("frame_done", int'(frame_done), int'(m_done));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (exp_we()) begin
                chk("fb_addr", int'(fb_addr), exp_addr(m_k));
                chk("fb_wdata", int'(fb_wdata), int'(m_q[0]));
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic drive(input bit fs, input bit pv, input logic [15:0] pd);
        frame_start = fs;
        pixel_valid = pv;
        pixel_data  = pd;
        if (rdy_mode == 0) fb_ready = 1'b1;
        else if (rdy_mode == 2) fb_ready = 1'b0;
        else fb_ready = ($urandom_range(0, 99) < 70);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    initial begin
`ifdef FB_VFLIP_EN
        exp1 = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};
`else
        exp1 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
`endif
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_wdata", int'(fb_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Pixels while idle are ignored
        clear_log();
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'(32'h50 + i));
        idle(3);
        chk("idle_writes", log_addr.size(), 0);

        // Full frame, ready always high
        clear_log();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 1; i <= N; i++) drive(1'b0, 1'b1, 16'(i));
        idle(6);
        chk("t1_count", log_addr.size(), N);
        for (int i = 0; i < N && i < log_addr.size(); i++) begin
            chk("t1_addr", log_addr[i], exp1[i]);
            chk("t1_data", log_data[i], i + 1);
        end
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy", int'(busy), 0);

        // Five-cycle stall mid-frame
        clear_log();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 1; i <= N; i++) begin
            if (i == 6) rdy_mode = 2;
            if (i == 11) rdy_mode = 0;
            drive(1'b0, 1'b1, 16'(32'h20 + i));
        end
        idle(12);
        chk("t2_count", log_addr.size(), N);
        for (int i = 0; i < N && i < log_data.size(); i++) chk("t2_data", log_data[i], 32'h20 + i + 1);
        chk("t2_overflow", int'(overflow), 0);
        chk("t2_done_cnt", done_cnt, 1);

        // FIFO overflow with memory stalled
        clear_log();
        rdy_mode = 2;
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 16'(32'h30 + i));
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_fb_we", int'(fb_we), 1);
        chk("t3_head", int'(fb_wdata), 32'h30);
        rdy_mode = 0;
        idle(12);
        chk("t3_count", log_addr.size(), 8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            chk("t3_addr", log_addr[i], exp1[i]);
            chk("t3_data", log_data[i], 32'h30 + i);
        end
        chk("t3_busy", int'(busy), 1);
        drive(1'b1, 1'b0, 16'h0);
        chk("t3_ovf_clear", int'(overflow), 0);

        // Restart mid-frame; pixel in the frame_start cycle is dropped
        clear_log();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'(32'h40 + i));
        idle(3);
        drive(1'b1, 1'b1, 16'hDEAD);
        for (int i = 0; i < N; i++) drive(1'b0, 1'b1, 16'(32'h100 + i));
        idle(6);
        chk("t4_count", log_addr.size(), 5 + N);
        if (log_addr.size() > 5) begin
            chk("t4_old_last", log_data[4], 32'h44);
            chk("t4_new_addr", log_addr[5], exp1[0]);
            chk("t4_new_data", log_data[5], 32'h100);
        end
        chk("t4_done_cnt", done_cnt, 1);

        // Asynchronous reset mid-frame
        rdy_mode = 2;
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 16'($urandom));
        chk("t5_pre_ovf", int'(overflow), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_fb_we", int'(fb_we), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(frame_done), 0);
        chk("t5_ovf", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Random frames with random ready, gaps and restarts
        rdy_mode = 1;
        for (int f = 0; f < 10; f++) begin
            int cyc;
            cyc = 0;
            drive(1'b1, 1'b0, 16'h0);
            while (m_wr && cyc < 400) begin
                drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), 16'($urandom));
                cyc++;
            end
            chk("rand_frame_complete", int'(m_wr), 0);
            idle(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
